kbd_scan_ctrl: RTL and testbench

KBD_SCAN_CTRL -- requirements
Module: kbd_scan_ctrl

---
 rtl/kbd_scan_ctrl_pkg.sv | 7 +
 rtl/kbd_scan_ctrl_scancode_ascii.sv | 51 +++++
 rtl/kbd_scan_ctrl.sv | 84 ++++++++
 tb/tb_kbd_scan_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/kbd_scan_ctrl_pkg.sv
// kbd_scan_ctrl_pkg: shared FSM states and PS/2 scan-code constants.
package kbd_scan_ctrl_pkg;
  typedef enum logic [1:0] {S_IDLE, S_POP, S_GAP} state_t;
  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  localparam logic [7:0] NO_ASCII   = 8'h00;
endpackage

// File: rtl/kbd_scan_ctrl_scancode_ascii.sv
// scancode_ascii: set-2 scan code to lowercase ASCII for letters, digits and space.
module scancode_ascii
  import kbd_scan_ctrl_pkg::*;
(
  input  logic [7:0] code,
  output logic [7:0] ascii
);
  always_comb begin
    ascii = NO_ASCII;
    case (code)
      8'h1C: ascii = 8'h61;
      8'h32: ascii = 8'h62;
      8'h21: ascii = 8'h63;
      8'h23: ascii = 8'h64;
      8'h24: ascii = 8'h65;
      8'h2B: ascii = 8'h66;
      8'h34: ascii = 8'h67;
      8'h33: ascii = 8'h68;
      8'h43: ascii = 8'h69;
      8'h3B: ascii = 8'h6A;
      8'h42: ascii = 8'h6B;
      8'h4B: ascii = 8'h6C;
      8'h3A: ascii = 8'h6D;
      8'h31: ascii = 8'h6E;
      8'h44: ascii = 8'h6F;
      8'h4D: ascii = 8'h70;
      8'h15: ascii = 8'h71;
      8'h2D: ascii = 8'h72;
      8'h1B: ascii = 8'h73;
      8'h2C: ascii = 8'h74;
      8'h3C: ascii = 8'h75;
      8'h2A: ascii = 8'h76;
      8'h1D: ascii = 8'h77;
      8'h22: ascii = 8'h78;
      8'h35: ascii = 8'h79;
      8'h1A: ascii = 8'h7A;
      8'h45: ascii = 8'h30;
      8'h16: ascii = 8'h31;
      8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33;
      8'h25: ascii = 8'h34;
      8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36;
      8'h3D: ascii = 8'h37;
      8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h29: ascii = 8'h20;
      default: ascii = NO_ASCII;
    endcase
  end
endmodule

// File: rtl/kbd_scan_ctrl.sv
// kbd_scan_ctrl: pops bytes from the ps2_keyboard FIFO and tracks the single most recent held key.
module kbd_scan_ctrl
  import kbd_scan_ctrl_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int GAP_CYC = 1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       kb_data,
  input  logic             kb_ready,
  input  logic             kb_overflow,
  output logic             nextdata_n,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_down,
  output logic [7:0]       key_ascii,
  output logic             key_event,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ovf_seen
);
  localparam int GW = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;
  state_t state, state_nx;
  logic [GW-1:0] gap_cnt;
  logic [7:0] byte_r, rom_ascii;
  logic brk_f, ext_f, pop, is_brk, is_ext, same, make_new;
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= S_IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nx;
      gap_cnt <= state == S_GAP ? gap_cnt + 1'b1 : '0;
    end
  end
  always_comb begin
    state_nx   = state == S_IDLE ? (kb_ready ? S_POP : S_IDLE) :
                 state == S_POP  ? S_GAP :
                 (gap_cnt == GW'(GAP_CYC - 1) ? S_IDLE : S_GAP);
    nextdata_n = state != S_POP;
  end
  // A make matching the held key (code and prefix) is typematic repeat, not a new press.
  always_comb begin
    pop      = state == S_POP;
    is_brk   = byte_r == BREAK_CODE;
    is_ext   = byte_r == EXT_CODE;
    same     = byte_r == key_code && ext_f == key_ext;
    make_new = pop && !is_brk && !is_ext && !brk_f && !(key_down && same);
  end
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      byte_r    <= '0;
      brk_f     <= 1'b0;
      ext_f     <= 1'b0;
      key_code  <= '0;
      key_ext   <= 1'b0;
      key_down  <= 1'b0;
      key_event <= 1'b0;
      press_cnt <= '0;
      ovf_seen  <= 1'b0;
    end else begin
      key_event <= make_new;
      ovf_seen  <= ovf_seen | kb_overflow;
      if (state == S_IDLE && kb_ready) byte_r <= kb_data;
      if (pop) begin
        if (is_brk) brk_f <= 1'b1;
        else if (is_ext) ext_f <= 1'b1;
        else begin
          brk_f <= 1'b0;
          ext_f <= 1'b0;
          if (brk_f && same) key_down <= 1'b0;
          if (make_new) begin
            key_code  <= byte_r;
            key_ext   <= ext_f;
            key_down  <= 1'b1;
            press_cnt <= press_cnt + 1'b1;
          end
        end
      end
    end
  end
  scancode_ascii u_rom (.code(key_code), .ascii(rom_ascii));
  assign key_ascii = key_ext ? NO_ASCII : rom_ascii;
endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// tb_kbd_scan_ctrl: directed and random byte streams checked against a byte-level key model.
module tb_kbd_scan_ctrl;
  logic clk = 1'b0, clrn = 1'b0, kb_ready = 1'b0, kb_overflow = 1'b0;
  logic [7:0] kb_data = 8'h00;
  logic nextdata_n, key_ext, key_down, key_event, ovf_seen;
  logic [7:0] key_code, key_ascii, press_cnt;
  int errors = 0, checks = 0, pops = 0, adj = 0;
  logic prev_low = 1'b0;
  logic [7:0] m_code, m_cnt;
  logic m_ext, m_down, m_brk, m_xf, m_evt, m_ovf;
  localparam logic [7:0] LET [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
    8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  localparam logic [7:0] DIG [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
  localparam logic [7:0] POOL [8] = '{8'h1C,8'h1B,8'h45,8'h29,8'h75,8'hF0,8'hE0,8'hF0};

  kbd_scan_ctrl dut (.clk(clk), .clrn(clrn), .kb_data(kb_data), .kb_ready(kb_ready),
    .kb_overflow(kb_overflow), .nextdata_n(nextdata_n), .key_code(key_code), .key_ext(key_ext),
    .key_down(key_down), .key_ascii(key_ascii), .key_event(key_event), .press_cnt(press_cnt),
    .ovf_seen(ovf_seen));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (clrn && !nextdata_n) begin
      pops <= pops + 1;
      if (prev_low) adj <= adj + 1;
    end
    prev_low <= clrn && !nextdata_n;
  end

  function automatic logic [7:0] ref_ascii(input logic [7:0] c, input logic e);
    ref_ascii = 8'h00;
    if (!e) begin
      for (int i = 0; i < 26; i++) if (c == LET[i]) ref_ascii = 8'(8'h61 + i);
      for (int i = 0; i < 10; i++) if (c == DIG[i]) ref_ascii = 8'(8'h30 + i);
      if (c == 8'h29) ref_ascii = 8'h20;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_code = 0; m_ext = 0; m_down = 0; m_brk = 0; m_xf = 0; m_cnt = 0; m_evt = 0; m_ovf = 0;
  endtask

  task automatic apply(input logic [7:0] b);
    m_evt = 0;
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_xf = 1;
    else if (m_brk) begin
      if (b == m_code && m_xf == m_ext) m_down = 0;
      m_brk = 0; m_xf = 0;
    end else begin
      if (!(m_down && b == m_code && m_xf == m_ext)) begin
        m_code = b; m_ext = m_xf; m_down = 1; m_evt = 1; m_cnt = m_cnt + 8'd1;
      end
      m_xf = 0;
    end
  endtask

  task automatic check_all(input string tag, input logic with_evt);
    chk({tag, ".key_code"}, key_code, m_code);
    chk({tag, ".key_ext"}, key_ext, m_ext);
    chk({tag, ".key_down"}, key_down, m_down);
    chk({tag, ".key_ascii"}, key_ascii, ref_ascii(m_code, m_ext));
    chk({tag, ".press_cnt"}, press_cnt, m_cnt);
    chk({tag, ".ovf_seen"}, ovf_seen, m_ovf);
    if (with_evt) chk({tag, ".key_event"}, key_event, m_evt);
  endtask

  task automatic send_byte(input logic [7:0] b, input string tag);
    logic got = 1'b0;
    @(negedge clk);
    kb_data = b;
    kb_ready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (!nextdata_n) got = 1'b1;
    end
    kb_ready = 1'b0;
    chk({tag, ".pop_seen"}, got, 1);
    @(negedge clk);
    apply(b);
    check_all(tag, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".nextdata_n"}, nextdata_n, 1);
    chk({tag, ".key_code"}, key_code, 0);
    chk({tag, ".key_ext"}, key_ext, 0);
    chk({tag, ".key_down"}, key_down, 0);
    chk({tag, ".key_event"}, key_event, 0);
    chk({tag, ".press_cnt"}, press_cnt, 0);
    chk({tag, ".ovf_seen"}, ovf_seen, 0);
  endtask

  initial begin
    int p0, lows, first, last;
    logic even;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    clrn = 1'b1;
    // press and release 'a'
    p0 = pops;
    send_byte(8'h1C, "r039_make");
    chk("r039_ascii", key_ascii, 8'h61);
    send_byte(8'hF0, "r039_brk");
    send_byte(8'h1C, "r039_rel");
    chk("r039_pops", pops - p0, 3);
    chk("r039_cnt", press_cnt, 1);
    chk("r039_down", key_down, 0);
    // typematic repeat of 's'
    foreach (POOL[i]) if (i < 3) send_byte(8'h1B, "r040_rep");
    send_byte(8'hF0, "r040_brk");
    send_byte(8'h1B, "r040_rel");
    chk("r040_cnt", press_cnt, 2);
    chk("r040_down", key_down, 0);
    // extended key: plain release must not clear it, extended release must
    send_byte(8'hE0, "r041_e0");
    send_byte(8'h75, "r041_make");
    chk("r041_ext", key_ext, 1);
    chk("r041_ascii", key_ascii, 0);
    send_byte(8'hF0, "r041_f0");
    send_byte(8'h75, "r041_plainrel");
    chk("r041_still_down", key_down, 1);
    send_byte(8'hE0, "r041_e0b");
    send_byte(8'hF0, "r041_f0b");
    send_byte(8'h75, "r041_extrel");
    chk("r041_released", key_down, 0);
    // back-to-back pops with ready held high
    @(negedge clk);
    kb_data = 8'h1C;
    kb_ready = 1'b1;
    lows = 0; first = -1; last = -1; even = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!nextdata_n) begin
        if (last >= 0 && i - last != 3) even = 1'b0;
        if (first < 0) first = i;
        last = i;
        lows++;
        apply(8'h1C);
      end
    end
    kb_ready = 1'b0;
    chk("r042_pulses", lows, 10);
    chk("r042_spacing", even, 1);
    repeat (3) @(negedge clk);
    check_all("r042_state", 1'b0);
    // random stream
    for (int n = 0; n < 150; n++) begin
      int k;
      k = $urandom_range(0, 9);
      send_byte(k < 8 ? POOL[k] : 8'($urandom_range(0, 255)), "rand");
    end
    chk("adjacent_pops", adj, 0);
    // sticky overflow
    @(negedge clk);
    kb_overflow = 1'b1;
    @(negedge clk);
    kb_overflow = 1'b0;
    m_ovf = 1'b1;
    chk("ovf_set", ovf_seen, 1);
    repeat (4) @(negedge clk);
    chk("ovf_sticky", ovf_seen, 1);
    // reset discards pending break; release with ready high pops immediately
    send_byte(8'h1C, "r044_make");
    send_byte(8'hF0, "r044_f0");
    clrn = 1'b0;
    #1;
    check_reset_outputs("r044_reset");
    model_reset();
    kb_data = 8'h1C;
    kb_ready = 1'b1;
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    chk("r036_first_pop", nextdata_n, 0);
    kb_ready = 1'b0;
    @(negedge clk);
    apply(8'h1C);
    check_all("r044_after", 1'b1);
    chk("r044_is_make", key_down, 1);
    // counter wrap: 256 alternating makes from a fresh reset
    @(negedge clk);
    clrn = 1'b0;
    model_reset();
    @(negedge clk);
    clrn = 1'b1;
    for (int n = 0; n < 256; n++) send_byte(n[0] ? 8'h1B : 8'h1C, "r043");
    chk("r043_wrap", press_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
